mpcu_opunit: RTL and testbench

- Operational (datapath) unit driven by the microprogram control unit; the responder end of the control/condition interface.
- Each cycle it receives the current microoperation code (state Y0..Yk) and executes the matching register transfer.
- Returns condition flags x1/x2 that steer the control unit's branches.
- Implements a W-bit unsigned shift-add multiplier: the control graph's Y4/Y5 loop is the add-shift loop, and Y2/Y3/Y7 is the zero-operand fast path.

---
 rtl/mpcu_opunit_pkg.sv | 18 +
 rtl/mpcu_opunit.sv | 91 +++++++++
 tb/tb_mpcu_opunit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mpcu_opunit_pkg.sv
// Shared microoperation encoding between the microprogram control unit and the
// operational unit.
package mpcu_opunit_pkg;

  typedef enum logic [3:0] {
    MopY0 = 4'd0,
    MopY1 = 4'd1,
    MopY2 = 4'd2,
    MopY3 = 4'd3,
    MopY4 = 4'd4,
    MopY5 = 4'd5,
    MopY6 = 4'd6,
    MopY7 = 4'd7,
    MopY8 = 4'd8,
    MopYk = 4'd9
  } mop_e;

endpackage

// File: rtl/mpcu_opunit.sv
// Operational unit for a shift-add unsigned multiplier; executes one register
// transfer per microoperation code and returns condition flags to the control unit.
module mpcu_opunit
  import mpcu_opunit_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [3:0]     i_mop,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_x1,
  output logic           o_x2,
  output logic [2*W-1:0] o_result,
  output logic           o_valid,
  output logic           o_zero
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [2*W-1:0] ra_q, ra_d;
  logic [W-1:0]   rb_q, rb_d;
  logic [2*W-1:0] rp_q, rp_d;
  logic [CW-1:0]  rcnt_q, rcnt_d;
  logic [2*W-1:0] result_q, result_d;
  logic           valid_q, valid_d;
  logic           zero_q, zero_d;

  always_comb begin
    ra_d     = ra_q;
    rb_d     = rb_q;
    rp_d     = rp_q;
    rcnt_d   = rcnt_q;
    result_d = result_q;
    valid_d  = valid_q;
    zero_d   = zero_q;
    case (i_mop)
      MopY0: begin
        ra_d    = {{W{1'b0}}, i_a};
        rb_d    = i_b;
        rp_d    = '0;
        rcnt_d  = '0;
        valid_d = 1'b0;
        zero_d  = 1'b0;
      end
      MopY2: rp_d = '0;
      MopY3: zero_d = 1'b1;
      MopY4: begin
        if (rb_q[0]) begin
          rp_d = rp_q + ra_q;
        end
        ra_d   = ra_q << 1;
        rb_d   = rb_q >> 1;
        rcnt_d = rcnt_q + CW'(1);
      end
      MopY6, MopY7: result_d = rp_q;
      MopY8: valid_d = 1'b1;
      // Y1/Y5 are branch cycles; Yk and unused codes hold everything.
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ra_q     <= '0;
      rb_q     <= '0;
      rp_q     <= '0;
      rcnt_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rp_q     <= rp_d;
      rcnt_q   <= rcnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
    end
  end

  // Flags depend on registers only, so they are stable across a whole branch cycle.
  assign o_x1     = |rb_q;
  assign o_x2     = ~|rb_q;
  assign o_result = result_q;
  assign o_valid  = valid_q;
  assign o_zero   = zero_q;

endmodule

// File: tb/tb_mpcu_opunit.sv
// Directed bench for mpcu_opunit: plays the control unit's microoperation sequences
// from a vector table and checks flags, product and status against hand values.
module tb_mpcu_opunit;
  import mpcu_opunit_pkg::*;

  localparam int unsigned W = 8;

  logic           i_clk;
  logic           i_rst_n;
  logic [3:0]     i_mop;
  logic [W-1:0]   i_a;
  logic [W-1:0]   i_b;
  logic           o_x1;
  logic           o_x2;
  logic [2*W-1:0] o_result;
  logic           o_valid;
  logic           o_zero;

  mpcu_opunit #(.W(W)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_mop    (i_mop),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_x1     (o_x1),
    .o_x2     (o_x2),
    .o_result (o_result),
    .o_valid  (o_valid),
    .o_zero   (o_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    int             iters;
    bit             zpath;
    bit             stall;
  } vec_t;

  vec_t           vecs[9];
  int             total = 0;
  int             bad = 0;
  logic [2*W-1:0] last_prod = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a code just after the falling edge; sample 1 ns later, mid-cycle.
  task automatic step(input logic [3:0] mop);
    @(negedge i_clk);
    i_mop = mop;
    #1;
  endtask

  task automatic run(input vec_t v);
    logic [2*W-1:0] prev;
    prev = last_prod;
    i_a = v.a;
    i_b = v.b;
    step(MopY0);
    step(MopY1);
    i_a = W'($urandom);
    i_b = W'($urandom);
    chk("x1_in_y1", 32'(o_x1), 32'(!v.zpath));
    chk("valid_low_y1", 32'(o_valid), 0);
    chk("result_held_y1", 32'(o_result), 32'(prev));
    if (v.zpath) begin
      step(MopY2);
      step(MopY3);
      step(MopY7);
      chk("zero_set_y7", 32'(o_zero), 1);
      chk("result_held_y7", 32'(o_result), 32'(prev));
      step(MopY8);
    end else begin
      for (int i = 0; i < v.iters; i++) begin
        step(MopY4);
        chk("result_held_y4", 32'(o_result), 32'(prev));
        if (v.stall) begin
          for (int s = 0; s < 3; s++) begin
            step(4'd12);
            chk("x2_in_stall", 32'(o_x2), 32'(i == v.iters - 1));
          end
        end
        step(MopY5);
        chk("x2_in_y5", 32'(o_x2), 32'(i == v.iters - 1));
      end
      step(MopY6);
      chk("result_held_y6", 32'(o_result), 32'(prev));
      step(MopY8);
    end
    chk("result_after_store", 32'(o_result), 32'(v.prod));
    chk("valid_low_y8", 32'(o_valid), 0);
    step(MopYk);
    chk("valid_yk", 32'(o_valid), 1);
    chk("result_yk", 32'(o_result), 32'(v.prod));
    chk("zero_yk", 32'(o_zero), 32'(v.zpath));
    last_prod = v.prod;
  endtask

  initial begin
    vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143,   iters: 4, zpath: 1'b0, stall: 1'b0};
    vecs[1] = '{a: 8'd200, b: 8'd0,   prod: 16'd0,     iters: 0, zpath: 1'b1, stall: 1'b0};
    vecs[2] = '{a: 8'd255, b: 8'd255, prod: 16'd65025, iters: 8, zpath: 1'b0, stall: 1'b0};
    vecs[3] = '{a: 8'd7,   b: 8'd6,   prod: 16'd42,    iters: 3, zpath: 1'b0, stall: 1'b0};
    vecs[4] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143,   iters: 4, zpath: 1'b0, stall: 1'b1};
    vecs[5] = '{a: 8'd3,   b: 8'd5,   prod: 16'd15,    iters: 3, zpath: 1'b0, stall: 1'b0};
    vecs[6] = '{a: 8'd1,   b: 8'd1,   prod: 16'd1,     iters: 1, zpath: 1'b0, stall: 1'b0};
    vecs[7] = '{a: 8'd0,   b: 8'd255, prod: 16'd0,     iters: 8, zpath: 1'b0, stall: 1'b0};
    vecs[8] = '{a: 8'd128, b: 8'd128, prod: 16'd16384, iters: 8, zpath: 1'b0, stall: 1'b0};

    i_rst_n = 1'b0;
    i_mop   = 4'(MopYk);
    i_a     = '0;
    i_b     = '0;
    #23;
    chk("rst_x1", 32'(o_x1), 0);
    chk("rst_x2", 32'(o_x2), 1);
    chk("rst_result", 32'(o_result), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_zero", 32'(o_zero), 0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        // Abort a 13x11 run asynchronously during its second Y4.
        i_a = 8'd13;
        i_b = 8'd11;
        step(MopY0);
        step(MopY1);
        step(MopY4);
        step(MopY5);
        step(MopY4);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_result", 32'(o_result), 0);
        chk("midrst_valid", 32'(o_valid), 0);
        chk("midrst_zero", 32'(o_zero), 0);
        chk("midrst_x2", 32'(o_x2), 1);
        i_rst_n = 1'b1;
        last_prod = '0;
        step(MopYk);
        chk("midrst_hold", 32'(o_result), 0);
      end
      run(vecs[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
